multdiv_ctrl: RTL and testbench

Sequencer sitting between the processor's execute stage and the multi-cycle multiply/divide unit. It accepts a mult or div issue, latches the 32-bit operands and destination register, pulses the unit's start control, stalls the pipeline until the unit reports ready, then presents one writeback beat. On a unit exception it redirects the write to $r30 with the status code.

---
 rtl/multdiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_multdiv_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Sequencer between execute and the multi-cycle multiply/divide unit.
// Optional WAIT watchdog enabled by defining MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_mult,
    input  logic        issue_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [4:0]  rd_in,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_WB
    } state_e;

    if (2 ** CNT_W <= TIMEOUT) begin : g_cnt_w_too_small
        $error("CNT_W too narrow for TIMEOUT");
    end

    state_e      state_q, state_d;
    logic        is_div_q, is_div_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  rd_q, rd_d;
    logic        exc_q, exc_d;
    logic        cmul_q, cmul_d;
    logic        cdiv_q, cdiv_d;
`ifdef MULTDIV_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    logic issue;
    logic in_wb;

    assign issue = issue_mult | issue_div;
    assign in_wb = (state_q == S_WB);

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        rd_d     = rd_q;
        exc_d    = exc_q;
        cmul_d   = 1'b0;
        cdiv_d   = 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            S_IDLE, S_WB: begin
                if (issue) begin
                    // mult has priority when both issue lines are high
                    state_d  = S_START;
                    is_div_d = ~issue_mult;
                    a_d      = operand_a;
                    b_d      = operand_b;
                    rd_d     = rd_in;
                    cmul_d   = issue_mult;
                    cdiv_d   = ~issue_mult;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef MULTDIV_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (md_ready) begin
                    state_d = S_WB;
                    res_d   = md_result;
                    exc_d   = md_exception;
                end else begin
`ifdef MULTDIV_TIMEOUT_EN
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_d = S_WB;
                        exc_d   = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            rd_q     <= '0;
            exc_q    <= 1'b0;
            cmul_q   <= 1'b0;
            cdiv_q   <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            rd_q     <= rd_d;
            exc_q    <= exc_d;
            cmul_q   <= cmul_d;
            cdiv_q   <= cdiv_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign ctrl_mult = cmul_q;
    assign ctrl_div  = cdiv_q;
    assign md_a      = a_q;
    assign md_b      = b_q;

    assign stall = (state_q == S_START) | (state_q == S_WAIT) | issue;

    // exceptions redirect to $r30 with status 4 (mult) or 5 (div)
    assign wb_valid = in_wb & (exc_q | (rd_q != 5'd0));
    assign wb_rd    = !in_wb ? 5'd0 : (exc_q ? 5'd30 : rd_q);
    assign wb_data  = !in_wb ? 32'd0 :
                      (exc_q ? (is_div_q ? 32'd5 : 32'd4) : res_q);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a writeback scoreboard.
// Covers timeout path when MULTDIV_TIMEOUT_EN is defined.
module tb_multdiv_ctrl;

    logic        clock;
    logic        reset;
    logic        issue_mult;
    logic        issue_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  rd_in;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .issue_mult   (issue_mult),
        .issue_div    (issue_div),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .rd_in        (rd_in),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .md_a         (md_a),
        .md_b         (md_b),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t sb_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every writeback beat must match the oldest expectation.
    always @(negedge clock) begin
        wb_t e;
        if (wb_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_cmul"}, {31'd0, ctrl_mult}, 32'd0);
        chk({tag, "_cdiv"}, {31'd0, ctrl_div}, 32'd0);
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_mda"}, md_a, 32'd0);
        chk({tag, "_mdb"}, md_b, 32'd0);
        chk({tag, "_wbrd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wbdata"}, wb_data, 32'd0);
    endtask

    // Issue in the current cycle, unit ready k cycles after the pulse.
    // Returns inside the WB cycle.
    task automatic run_op(input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k,
                          input logic [31:0] res, input bit exc,
                          input bit stray);
        wb_t e;
        bit  ev;
        issue_mult   = m;
        issue_div    = d;
        operand_a    = a;
        operand_b    = b;
        rd_in        = rd;
        md_ready     = stray;
        md_result    = 32'hdead_beef;
        md_exception = 1'b0;
        ev = exc || (rd != 5'd0);
        e.rd   = exc ? 5'd30 : rd;
        e.data = exc ? (m ? 32'd4 : 32'd5) : res;
        if (ev) sb_q.push_back(e);
        #1;
        chk("stall_issue", {31'd0, stall}, 32'd1);
        @(negedge clock);
        issue_mult = 1'b0;
        issue_div  = 1'b0;
        #1;
        chk("start_cmul", {31'd0, ctrl_mult}, {31'd0, m});
        chk("start_cdiv", {31'd0, ctrl_div}, {31'd0, !m});
        chk("start_stall", {31'd0, stall}, 32'd1);
        chk("start_mda", md_a, a);
        chk("start_mdb", md_b, b);
        for (int i = 2; i <= k; i++) begin
            @(negedge clock);
            md_ready = 1'b0;
            #1;
            chk("wait_stall", {31'd0, stall}, 32'd1);
            chk("wait_ctrl", {30'd0, ctrl_mult, ctrl_div}, 32'd0);
        end
        @(negedge clock);
        md_ready     = 1'b1;
        md_result    = res;
        md_exception = exc;
        #1;
        chk("ready_stall", {31'd0, stall}, 32'd1);
        chk("ready_wbv", {31'd0, wb_valid}, 32'd0);
        @(negedge clock);
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'hdead_beef;
        #1;
        chk("wb_stall", {31'd0, stall}, 32'd0);
        chk("wb_valid", {31'd0, wb_valid}, {31'd0, ev});
    endtask

    initial begin
        int c;
        reset        = 1'b1;
        issue_mult   = 1'b0;
        issue_div    = 1'b0;
        operand_a    = '0;
        operand_b    = '0;
        rd_in        = '0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = '0;
        repeat (2) @(negedge clock);
        #1;
        chk_zero("rst");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // mult 6*7 into r7, ready 17 cycles after the pulse
        run_op(1, 0, 32'd6, 32'd7, 5'd7, 17, 32'd42, 0, 0);
        @(negedge clock);
        #1;
        chk("idle_wbv", {31'd0, wb_valid}, 32'd0);
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("hold_mda", md_a, 32'd6);
        chk("hold_mdb", md_b, 32'd7);

        // div by zero with exception
        run_op(0, 1, 32'd5, 32'd0, 5'd3, 4, 32'd0, 1, 0);
        @(negedge clock);

        // mult to r0: no writeback
        run_op(1, 0, 32'd3, 32'd4, 5'd0, 2, 32'd12, 0, 0);
        @(negedge clock);

        // both issues plus stray ready: mult wins, stray ignored
        run_op(1, 1, 32'd9, 32'd9, 5'd4, 3, 32'd81, 0, 1);
        @(negedge clock);

        // back-to-back: div issued in the WB cycle of a mult
        run_op(1, 0, 32'd2, 32'd3, 5'd11, 5, 32'd6, 0, 0);
        run_op(0, 1, 32'd100, 32'd7, 5'd12, 1, 32'd14, 0, 0);
        @(negedge clock);

        // reset mid-WAIT, then a late ready
        issue_mult = 1'b1;
        operand_a  = 32'd1;
        operand_b  = 32'd1;
        rd_in      = 5'd13;
        @(negedge clock);
        issue_mult = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        md_ready  = 1'b1;
        md_result = 32'd77;
        #1;
        chk_zero("midrst");
        @(negedge clock);
        md_ready = 1'b0;
        #1;
        chk_zero("late_rdy");

`ifdef MULTDIV_TIMEOUT_EN
        @(negedge clock);
        issue_mult = 1'b1;
        operand_a  = 32'd8;
        operand_b  = 32'd8;
        rd_in      = 5'd9;
        sb_q.push_back('{rd: 5'd30, data: 32'd4});
        c = 0;
        while (c < 200) begin
            @(negedge clock);
            issue_mult = 1'b0;
            c++;
            #1;
            if (wb_valid === 1'b1) break;
        end
        chk("timeout_cycle", c, 32'd66);
        chk("timeout_wbrd", {27'd0, wb_rd}, 32'd30);
        md_ready  = 1'b1;
        md_result = 32'd64;
        repeat (3) @(negedge clock);
        md_ready = 1'b0;
        #1;
        chk("post_to_stall", {31'd0, stall}, 32'd0);
`else
        @(negedge clock);
        issue_mult = 1'b1;
        rd_in      = 5'd9;
        @(negedge clock);
        issue_mult = 1'b0;
        repeat (100) @(negedge clock);
        #1;
        chk("nowdt_stall", {31'd0, stall}, 32'd1);
        chk("nowdt_wbv", {31'd0, wb_valid}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        c = 0;
`endif

        repeat (3) @(negedge clock);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
